// File: rtl/agc_pkg.sv
// Shared types and helpers for the multi-channel AGC gain stage.
// Latency: none (types and constant/combinational functions only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, unity-gain constant, lane bit-offset helpers,
// and the signed saturation helpers used by every component multiplier.
package agc_pkg;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } agc_state_e;

    // Unity gain in the unsigned fixed-point gain format.
    function automatic int unsigned UNITY_GAIN(input int unsigned gain_frac);
        return 32'd1 << gain_frac;
    endfunction

    // Bit offset of the I half of lane (ch, smp); lanes are {Q,I}, I low.
    function automatic int lane_i_lo(input int ch, input int smp,
                                     input int spb, input int sample_w);
        return (ch * spb + smp) * 2 * sample_w;
    endfunction

    function automatic int lane_q_lo(input int ch, input int smp,
                                     input int spb, input int sample_w);
        return lane_i_lo(ch, smp, spb, sample_w) + sample_w;
    endfunction

    // Values are carried as 64-bit signed so one helper serves any SAMPLE_W.
    function automatic logic is_sat(input logic signed [63:0] y, input int sample_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sample_w - 1));
        return (y > hi) || (y < lo);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] y,
                                                    input int sample_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sample_w - 1));
        if (y > hi) begin
            return hi;
        end else if (y < lo) begin
            return lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/agc_sat_mult.sv
// One I or Q component: gain multiply, arithmetic shift, saturate, sat flag.
// Latency: 2 advances (product register, then saturated result register).
// Backpressure: both registers hold while advance is low.
//
// Ports: aclk/areset clock and sync reset; advance pipeline enable;
// enable 0 = multiply by unity; gain unsigned gain; x input sample;
// y registered saturated output; sat flag for the beat held in the product register.
module agc_sat_mult
    import agc_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 12,
    parameter int GAIN_FRAC = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       advance,
    input  logic                       enable,
    input  logic [GAIN_W-1:0]          gain,
    input  logic signed [SAMPLE_W-1:0] x,
    output logic signed [SAMPLE_W-1:0] y,
    output logic                       sat
);

    localparam int PW = SAMPLE_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(UNITY_GAIN(GAIN_FRAC));

    logic [GAIN_W-1:0]   gain_eff;
    logic signed [GAIN_W:0] gain_s;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] shr;
    logic signed [63:0]   shr_ext;
    logic signed [63:0]   sat_val;
    logic                 sat_val_unused;

    // Bypass reuses the multiplier with unity so latency is identical and
    // the result can never saturate.
    assign gain_eff = enable ? gain : UNITY;
    assign gain_s   = $signed({1'b0, gain_eff});
    assign prod_c   = PW'(x) * PW'(gain_s);

    always_ff @(posedge aclk) begin
        if (areset) begin
            prod_q <= '0;
        end else if (advance) begin
            prod_q <= prod_c;
        end
    end

    assign shr     = prod_q >>> GAIN_FRAC;
    assign shr_ext = {{(64-PW){shr[PW-1]}}, shr};
    assign sat_val = saturate(shr_ext, SAMPLE_W);
    assign sat     = is_sat(shr_ext, SAMPLE_W);
    assign sat_val_unused = ^sat_val[63:SAMPLE_W];

    always_ff @(posedge aclk) begin
        if (areset) begin
            y <= '0;
        end else if (advance) begin
            y <= sat_val[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/agc_gain_apply_mc.sv
// Slot-latched, clamped per-channel gain applied to NUM_CH x SPB complex lanes.
// Latency: 2 accepted cycles from s-side handshake to m_axis_tvalid.
// Backpressure: single global advance; s_axis_tready = !m_axis_tvalid || m_axis_tready.
//
// Ports: aclk/areset; cfg_enable (0 = bypass), cfg_gain_max clamp ceiling,
// cfg_unlock / cfg_sat_clear pulses; gain_est/gain_est_valid estimate input;
// slot_detected / slot_finished pulses; s_axis_* input stream, m_axis_* output
// stream; gain_active gains in use, locked FSM status, sat_count saturation total.
module agc_gain_apply_mc
    import agc_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int SPB       = 2,
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 12,
    parameter int GAIN_FRAC = 8
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             cfg_enable,
    input  logic [GAIN_W-1:0]                cfg_gain_max,
    input  logic                             cfg_unlock,
    input  logic                             cfg_sat_clear,
    input  logic [NUM_CH*GAIN_W-1:0]         gain_est,
    input  logic                             gain_est_valid,
    input  logic                             slot_detected,
    input  logic                             slot_finished,
    input  logic [NUM_CH*SPB*2*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [NUM_CH*SPB*2*SAMPLE_W-1:0] m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [NUM_CH*GAIN_W-1:0]         gain_active,
    output logic                             locked,
    output logic [31:0]                      sat_count
);

    localparam int NCOMP = NUM_CH * SPB * 2;
    localparam int CNT_W = $clog2(NCOMP + 1);
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(UNITY_GAIN(GAIN_FRAC));

    // ---------------- FSM ----------------
    agc_state_e state_q;
    agc_state_e state_d;
    logic       gp_load;
    logic       ga_load;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_unlock) begin
            state_d = ACQUIRE;
        end else if ((state_q == ACQUIRE) && slot_detected) begin
            state_d = LOCKED;
        end
    end

    // ACQUIRE tracks the estimator continuously; LOCKED only latches at slot
    // boundaries so a slot is never processed with a changing gain.
    always_comb begin
        gp_load = 1'b0;
        ga_load = 1'b0;
        locked  = 1'b0;
        case (state_q)
            ACQUIRE: begin
                gp_load = gain_est_valid;
                ga_load = 1'b1;
            end
            LOCKED: begin
                gp_load = slot_detected;
                ga_load = slot_finished;
                locked  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Pipeline control ----------------
    logic adv;
    logic s1_vld;
    logic s1_last;
    logic s1_en;
    logic m_vld_q;
    logic m_last_q;
    logic [NCOMP-1:0] sat_vec;

    assign adv           = !m_vld_q || m_axis_tready;
    assign s_axis_tready = adv;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_last_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_en    <= 1'b0;
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
        end else if (adv) begin
            s1_vld   <= s_axis_tvalid;
            s1_last  <= s_axis_tlast;
            s1_en    <= cfg_enable;
            m_vld_q  <= s1_vld;
            m_last_q <= s1_last;
        end
    end

    // ---------------- Gain registers and datapath ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [GAIN_W-1:0] gp_q;
        logic [GAIN_W-1:0] ga_q;
        logic [GAIN_W-1:0] est_c;
        logic [GAIN_W-1:0] clamp_c;

        assign est_c   = gain_est[c*GAIN_W +: GAIN_W];
        assign clamp_c = (est_c > cfg_gain_max) ? cfg_gain_max : est_c;

        // ga takes the pre-edge gp, so a coincident load of both behaves
        // as a clean one-slot handover.
        always_ff @(posedge aclk) begin
            if (areset) begin
                gp_q <= UNITY;
                ga_q <= UNITY;
            end else begin
                if (gp_load) begin
                    gp_q <= clamp_c;
                end
                if (ga_load) begin
                    ga_q <= gp_q;
                end
            end
        end

        assign gain_active[c*GAIN_W +: GAIN_W] = ga_q;

        for (genvar s = 0; s < SPB; s++) begin : g_smp
            localparam int LANE = c * SPB + s;
            localparam int I_LO = lane_i_lo(c, s, SPB, SAMPLE_W);
            localparam int Q_LO = lane_q_lo(c, s, SPB, SAMPLE_W);

            logic signed [SAMPLE_W-1:0] yi;
            logic signed [SAMPLE_W-1:0] yq;

            agc_sat_mult #(
                .SAMPLE_W (SAMPLE_W),
                .GAIN_W   (GAIN_W),
                .GAIN_FRAC(GAIN_FRAC)
            ) u_i (
                .aclk   (aclk),
                .areset (areset),
                .advance(adv),
                .enable (cfg_enable),
                .gain   (ga_q),
                .x      (s_axis_tdata[I_LO +: SAMPLE_W]),
                .y      (yi),
                .sat    (sat_vec[2*LANE])
            );

            agc_sat_mult #(
                .SAMPLE_W (SAMPLE_W),
                .GAIN_W   (GAIN_W),
                .GAIN_FRAC(GAIN_FRAC)
            ) u_q (
                .aclk   (aclk),
                .areset (areset),
                .advance(adv),
                .enable (cfg_enable),
                .gain   (ga_q),
                .x      (s_axis_tdata[Q_LO +: SAMPLE_W]),
                .y      (yq),
                .sat    (sat_vec[2*LANE+1])
            );

            assign m_axis_tdata[I_LO +: SAMPLE_W] = yi;
            assign m_axis_tdata[Q_LO +: SAMPLE_W] = yq;
        end
    end

    // ---------------- Saturation counter ----------------
    logic [CNT_W-1:0] sat_num;
    logic [31:0]      sat_cnt_q;
    logic [32:0]      sat_sum;

    always_comb begin
        sat_num = '0;
        for (int i = 0; i < NCOMP; i++) begin
            sat_num = sat_num + CNT_W'(sat_vec[i]);
        end
    end

    assign sat_sum = {1'b0, sat_cnt_q} + 33'(sat_num);

    // Counts beats entering S2; sticks at all-ones instead of wrapping.
    always_ff @(posedge aclk) begin
        if (areset || cfg_sat_clear) begin
            sat_cnt_q <= '0;
        end else if (adv && s1_vld && s1_en) begin
            sat_cnt_q <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
        end
    end

    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_agc_gain_apply_mc.sv
// Self-checking bench for agc_gain_apply_mc with default parameters.
// Latency: checks output exactly 2 cycles after an accepted beat.
// Backpressure: exercises random m_axis_tready over a long ramp.
module tb_agc_gain_apply_mc;

    logic         aclk = 1'b0;
    logic         areset;
    logic         cfg_enable;
    logic [11:0]  cfg_gain_max;
    logic         cfg_unlock;
    logic         cfg_sat_clear;
    logic [23:0]  gain_est;
    logic         gain_est_valid;
    logic         slot_detected;
    logic         slot_finished;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [23:0]  gain_active;
    logic         locked;
    logic [31:0]  sat_count;

    always #5 aclk = ~aclk;

    agc_gain_apply_mc dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_enable    (cfg_enable),
        .cfg_gain_max  (cfg_gain_max),
        .cfg_unlock    (cfg_unlock),
        .cfg_sat_clear (cfg_sat_clear),
        .gain_est      (gain_est),
        .gain_est_valid(gain_est_valid),
        .slot_detected (slot_detected),
        .slot_finished (slot_finished),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .gain_active   (gain_active),
        .locked        (locked),
        .sat_count     (sat_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_gain(input logic [11:0] g0, input logic [11:0] g1);
        gain_est       = {g1, g0};
        gain_est_valid = 1'b1;
        step();
        gain_est_valid = 1'b0;
        step();
    endtask

    function automatic logic [127:0] ramp(input int idx);
        logic [127:0] d;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            d[l*32 +: 16]      = 16'(idx * 8 + l * 2);
            d[l*32 + 16 +: 16] = 16'(idx * 8 + l * 2 + 1);
        end
        return d;
    endfunction

    typedef struct {
        logic [11:0] g0;
        logic [11:0] g1;
        logic [15:0] xi;
        logic [15:0] xq;
        logic        en;
        logic [15:0] e0i;
        logic [15:0] e0q;
        logic [15:0] e1i;
        logic [15:0] e1q;
        int          dsat;
    } vec_t;

    vec_t vt[8];

    initial begin
        int exp_sat;
        int src_idx;
        int out_idx;
        int cyc;
        logic s_hs;
        logic m_hs;
        logic [127:0] got_d;
        logic got_l;

        areset = 1'b1; cfg_enable = 1'b1; cfg_gain_max = 12'hFFF;
        cfg_unlock = 1'b0; cfg_sat_clear = 1'b0; gain_est = '0;
        gain_est_valid = 1'b0; slot_detected = 1'b0; slot_finished = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        exp_sat = 0;

        //            g0      g1      xi        xq        en    e0i       e0q       e1i       e1q    dsat
        vt[0] = '{12'h100, 12'h100, 16'h1234, 16'hEDCC, 1'b1, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC, 0};
        vt[1] = '{12'h200, 12'h200, 16'h5000, 16'hB000, 1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 8};
        vt[2] = '{12'h200, 12'h080, 16'h3000, 16'hC000, 1'b1, 16'h6000, 16'h8000, 16'h1800, 16'hE000, 0};
        vt[3] = '{12'h200, 12'h200, 16'h0100, 16'hFFFF, 1'b1, 16'h0200, 16'hFFFE, 16'h0200, 16'hFFFE, 0};
        vt[4] = '{12'h180, 12'h100, 16'h0003, 16'hFFFD, 1'b1, 16'h0004, 16'hFFFB, 16'h0003, 16'hFFFD, 0};
        vt[5] = '{12'h200, 12'h200, 16'h5000, 16'hB000, 1'b0, 16'h5000, 16'hB000, 16'h5000, 16'hB000, 0};
        vt[6] = '{12'hFFF, 12'hFFF, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 4};
        vt[7] = '{12'h000, 12'h000, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};

        // Reset state
        step(); step();
        areset = 1'b0;
        step();
        chk("rst_tvalid", 128'(m_tvalid), 128'(1'b0));
        chk("rst_tdata", m_tdata, 128'h0);
        chk("rst_tlast", 128'(m_tlast), 128'(1'b0));
        chk("rst_tready", 128'(s_tready), 128'(1'b1));
        chk("rst_gain", 128'(gain_active), 128'(24'h100100));
        chk("rst_locked", 128'(locked), 128'(1'b0));
        chk("rst_satcnt", 128'(sat_count), 128'(0));

        // Table-driven datapath vectors
        for (int i = 0; i < 8; i++) begin
            set_gain(vt[i].g0, vt[i].g1);
            chk($sformatf("v%0d_gain", i), 128'(gain_active), 128'({vt[i].g1, vt[i].g0}));
            cfg_enable = vt[i].en;
            s_tdata    = {4{vt[i].xq, vt[i].xi}};
            s_tvalid   = 1'b1;
            s_tlast    = i[0];
            step();
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            chk($sformatf("v%0d_early_vld", i), 128'(m_tvalid), 128'(1'b0));
            step();
            exp_sat += vt[i].dsat;
            chk($sformatf("v%0d_vld", i), 128'(m_tvalid), 128'(1'b1));
            chk($sformatf("v%0d_data", i), m_tdata,
                {vt[i].e1q, vt[i].e1i, vt[i].e1q, vt[i].e1i,
                 vt[i].e0q, vt[i].e0i, vt[i].e0q, vt[i].e0i});
            chk($sformatf("v%0d_last", i), 128'(m_tlast), 128'(i[0]));
            chk($sformatf("v%0d_sat", i), 128'(sat_count), 128'(exp_sat));
            cfg_enable = 1'b1;
            step();
        end

        // Clamp against cfg_gain_max
        cfg_gain_max = 12'h400;
        set_gain(12'h800, 12'h300);
        chk("clamp_gain", 128'(gain_active), 128'(24'h300400));
        cfg_gain_max = 12'hFFF;
        set_gain(12'h100, 12'h100);

        // Lock sequence
        gain_est = 24'h180180; gain_est_valid = 1'b1; slot_detected = 1'b1;
        step();
        gain_est_valid = 1'b0; slot_detected = 1'b0;
        chk("lock_locked", 128'(locked), 128'(1'b1));
        chk("lock_ga_hold", 128'(gain_active), 128'(24'h100100));
        gain_est = 24'h300300; gain_est_valid = 1'b1;
        step();
        gain_est_valid = 1'b0;
        step();
        chk("lock_est_ignored", 128'(gain_active), 128'(24'h100100));
        slot_finished = 1'b1;
        step();
        slot_finished = 1'b0;
        chk("lock_finish_ga", 128'(gain_active), 128'(24'h180180));
        gain_est = 24'h0C00C0; slot_detected = 1'b1; slot_finished = 1'b1;
        step();
        slot_detected = 1'b0; slot_finished = 1'b0;
        chk("lock_simul_ga", 128'(gain_active), 128'(24'h180180));
        chk("lock_simul_locked", 128'(locked), 128'(1'b1));
        slot_finished = 1'b1;
        step();
        slot_finished = 1'b0;
        chk("lock_simul_gp", 128'(gain_active), 128'(24'h0C00C0));
        cfg_unlock = 1'b1;
        step();
        cfg_unlock = 1'b0;
        chk("unlock", 128'(locked), 128'(1'b0));
        cfg_unlock = 1'b1; slot_detected = 1'b1;
        step();
        cfg_unlock = 1'b0; slot_detected = 1'b0;
        chk("unlock_prio", 128'(locked), 128'(1'b0));

        // Sat clear coincident with a saturating beat entering S2
        set_gain(12'h200, 12'h200);
        s_tdata = {4{16'hB000, 16'h5000}}; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0; cfg_sat_clear = 1'b1;
        step();
        cfg_sat_clear = 1'b0;
        chk("clr_sat", 128'(sat_count), 128'(0));
        chk("clr_data", m_tdata, {4{16'h8000, 16'h7FFF}});
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        step();
        chk("clr_recount", 128'(sat_count), 128'(8));

        // Backpressure ramp with unity gain
        set_gain(12'h100, 12'h100);
        src_idx = 0; out_idx = 0; cyc = 0;
        while (out_idx < 1000 && cyc < 8000) begin
            s_tvalid = (src_idx < 1000);
            s_tdata  = ramp(src_idx);
            s_tlast  = ((src_idx % 14) == 13);
            m_tready = ($urandom_range(0, 9) < 3);
            #1;
            s_hs  = s_tvalid && s_tready;
            m_hs  = m_tvalid && m_tready;
            got_d = m_tdata;
            got_l = m_tlast;
            @(posedge aclk);
            #1;
            cyc++;
            if (s_hs) src_idx++;
            if (m_hs) begin
                chk($sformatf("bp_data%0d", out_idx), got_d, ramp(out_idx));
                chk($sformatf("bp_last%0d", out_idx), 128'(got_l), 128'((out_idx % 14) == 13));
                out_idx++;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        chk("bp_count", 128'(out_idx), 128'(1000));
        step(); step(); step();
        chk("bp_no_dup", 128'(m_tvalid), 128'(1'b0));

        // Reset mid-stream drops the in-flight beat
        s_tdata = ramp(5); s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0; areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        chk("mrst_vld", 128'(m_tvalid), 128'(1'b0));
        chk("mrst_sat", 128'(sat_count), 128'(0));
        chk("mrst_gain", 128'(gain_active), 128'(24'h100100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
